// File: rtl/seven_seg_scan_driver.sv
// Multiplexed multi-digit seven-segment driver: binary-to-BCD (sequential
// double-dabble) or hex digit extraction, display register and digit scanner.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int DATA_WIDTH    = 14,
    parameter int INVERT_OUTPUT = 1,
    parameter int HEX_MODE      = 0,
    parameter int BLANK_LEADING = 1,
    parameter int REFRESH_DIV   = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            segments,
    output logic [NUM_DIGITS-1:0] digit_enable
);

    localparam int   BW    = 4 * NUM_DIGITS;
    localparam int   EXT_W = (DATA_WIDTH > BW) ? DATA_WIDTH : BW;
    localparam int   CW    = $clog2(DATA_WIDTH + 1);
    localparam int   PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int   IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic INV   = (INVERT_OUTPUT != 0);
    localparam logic [6:0] DASH  = 7'b1000000;
    localparam logic [6:0] BLANK = 7'b0000000;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bcd;
    logic [3:0]            bcd_top;
    logic                  ovf_acc;
    logic [CW-1:0]         shift_cnt;
    logic [BW+3:0]         adj;
    logic [BW+3:0]         shifted;
    logic                  carry;
    logic [EXT_W-1:0]      ext;
    logic                  hex_ovf;
    logic [6:0]            glyph_nxt [NUM_DIGITS];
    logic                  lead;
    logic [3:0]            nib;
    logic [6:0]            disp [NUM_DIGITS];
    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0:    glyph = 7'b0111111;
            4'h1:    glyph = 7'b0000110;
            4'h2:    glyph = 7'b1011011;
            4'h3:    glyph = 7'b1001111;
            4'h4:    glyph = 7'b1100110;
            4'h5:    glyph = 7'b1101101;
            4'h6:    glyph = 7'b1111101;
            4'h7:    glyph = 7'b0000111;
            4'h8:    glyph = 7'b1111111;
            4'h9:    glyph = 7'b1101111;
            4'hA:    glyph = 7'b1110111;
            4'hB:    glyph = 7'b1111100;
            4'hC:    glyph = 7'b0111001;
            4'hD:    glyph = 7'b1011110;
            4'hE:    glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    endfunction

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = (HEX_MODE != 0) ? COMMIT : CONVERT;
            CONVERT: if (shift_cnt == CW'(DATA_WIDTH - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One double-dabble step; the extra top nibble only exists to flag overflow.
    always_comb begin
        adj = {bcd_top, bcd};
        for (int i = 0; i <= NUM_DIGITS; i++) begin
            if (adj[4*i +: 4] > 4'd4) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        carry   = adj[BW+3];
        shifted = {adj[BW+2:0], shreg[DATA_WIDTH-1]};
    end

    always_comb begin
        ext     = EXT_W'(value);
        hex_ovf = 1'b0;
        for (int i = BW; i < EXT_W; i++) hex_ovf = hex_ovf | ext[i];
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && load) begin
            shift_cnt <= '0;
            shreg     <= value;
            bcd_top   <= 4'd0;
            if (HEX_MODE != 0) begin
                bcd     <= ext[BW-1:0];
                ovf_acc <= hex_ovf;
            end else begin
                bcd     <= '0;
                ovf_acc <= 1'b0;
            end
        end else if (state == CONVERT) begin
            shift_cnt          <= shift_cnt + 1'b1;
            shreg              <= shreg << 1;
            {bcd_top, bcd}     <= shifted;
            // Once the top nibble is nonzero the value can only grow, so latch it.
            ovf_acc            <= ovf_acc | carry | (shifted[BW+3:BW] != 4'd0);
        end
    end

    always_comb begin
        lead = (BLANK_LEADING != 0);
        nib  = 4'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if (nib != 4'd0 || i == 0) lead = 1'b0;
            if (ovf_acc)   glyph_nxt[i] = DASH;
            else if (lead) glyph_nxt[i] = BLANK;
            else           glyph_nxt[i] = glyph(nib);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= BLANK;
        end else if (state == COMMIT) begin
            overflow <= ovf_acc;
            for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= glyph_nxt[i];
        end
    end

    // Free-running scan; display updates never disturb it.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            segments     <= {7{INV}};
            digit_enable <= NUM_DIGITS'(1) ^ {NUM_DIGITS{INV}};
        end else begin
            segments     <= disp[idx] ^ {7{INV}};
            digit_enable <= (NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{INV}};
        end
    end

endmodule
